// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressable data memory: one request at a time, fixed wait
// states before the array access, little-endian W/H/B loads and stores.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 80,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int AW1   = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [7:0]        cnt;
  logic              err_p0;
  logic              we_p0;
  logic [2:0]        size_p0;
  logic [IDX_W-1:0]  addr_p0;
  logic [31:0]       wdata_p0;
  logic [2:0]        nb_p0;
  logic [31:0]       rd_raw;
  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept;
  logic              acc_err;
  logic [2:0]        acc_nb;
  logic [AW1-1:0]    last_byte;
  logic              access_edge;
  logic              do_write;

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      3'b000:         return 3'd4;
      3'b001, 3'b010: return 3'd2;
      default:        return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [31:0] raw);
    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;
    half_s = signed'(raw[15:0]);
    byte_s = signed'(raw[7:0]);
    case (size)
      3'b001:  return {16'h0000, raw[15:0]};
      3'b010:  return 32'(half_s);
      3'b011:  return {24'h000000, raw[7:0]};
      3'b100:  return 32'(byte_s);
      default: return raw;
    endcase
  endfunction

  // Accept stage: legality is decided on the live request, end address at ADDR_WIDTH+1 bits
  always_comb begin
    acc_nb    = size_bytes(req_size);
    last_byte = {1'b0, req_addr} + AW1'(acc_nb - 3'd1);
    acc_err   = (req_size > 3'b100)
             || ((req_size == 3'b000) && (req_addr[1:0] != 2'b00))
             || (((req_size == 3'b001) || (req_size == 3'b010)) && req_addr[0])
             || (last_byte >= AW1'(DEPTH_BYTES));
  end

  assign accept      = req_valid && (state == IDLE);
  assign access_edge = (state == WAIT) && (cnt == 8'd0);
  assign do_write    = access_edge && !err_p0 && we_p0;
  assign nb_p0       = size_bytes(size_p0);

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = WAIT;
      end
      WAIT: if (cnt == 8'd0) state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Errors still pass through WAIT with a zero count so they answer one cycle after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 8'd0;
      err_p0     <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= acc_err ? 8'd0 : 8'(WAIT_STATES);
        err_p0 <= acc_err;
      end else if ((state == WAIT) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
      if (access_edge) begin
        resp_err   <= err_p0;
        resp_rdata <= (err_p0 || we_p0) ? 32'h0 : extend_load(size_p0, rd_raw);
      end else if ((state == RESP) && resp_ready) begin
        resp_rdata <= 32'h0;
        resp_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      addr_p0  <= req_addr[IDX_W-1:0];
      wdata_p0 <= req_wdata;
    end
  end

  // Access stage: byte lanes beyond the access size are neither read nor written
  always_comb begin
    rd_raw = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nb_p0) rd_raw[8*k +: 8] = mem[addr_p0 + IDX_W'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nb_p0) mem[addr_p0 + IDX_W'(k)] <= wdata_p0[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed vector table, randomized traffic against a
// byte-array model, response stall and asynchronous reset during a pending store.
module tb_data_memory_ctrl;

  localparam int DEPTH = 80;
  localparam int WS_A  = 1;
  localparam int WS_B  = 3;

  logic        clk;
  logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, busy;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        rst_b, req_valid_b, req_ready_b, req_we_b, resp_valid_b, resp_ready_b, resp_err_b, busy_b;
  logic [2:0]  req_size_b;
  logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [0:DEPTH-1];

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          stall;
  } vec_t;
  vec_t tbl[$];

  data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .WAIT_STATES(WS_A)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy));

  data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .WAIT_STATES(WS_B)) u_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_size(req_size_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .resp_valid(resp_valid_b),
    .resp_ready(resp_ready_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic we, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er,
                              input int st);
    vec_t v;
    v.we = we; v.sz = sz; v.addr = a; v.wd = wd; v.rd = rd; v.err = er; v.stall = st;
    tbl.push_back(v);
  endfunction

  // Reference: access rules applied to a plain byte array with integer arithmetic
  task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    longint a, v;
    int nb;
    a = longint'(addr);
    case (sz)
      3'd0:       nb = 4;
      3'd1, 3'd2: nb = 2;
      3'd3, 3'd4: nb = 1;
      default:    nb = 0;
    endcase
    rd = 32'h0;
    if (nb == 0) er = 1'b1;
    else         er = ((a % nb) != 0) || ((a + nb) > DEPTH);
    if (!er) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem_m[int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < nb; k++) v += longint'(mem_m[int'(a) + k]) << (8 * k);
        if (sz == 3'd2 && v >= 32768) v -= 65536;
        if (sz == 3'd4 && v >= 128)   v -= 256;
        rd = v[31:0];
      end
    end
  endtask

  task automatic run_txn(input string nm, input logic we, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int lat;
    int exp_lat;
    exp_lat = exp_err ? 1 : 1 + WS_A;
    @(negedge clk);
    chk({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    chk({nm, " busy after accept"}, {31'd0, busy}, 32'd1);
    chk({nm, " req_ready after accept"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " rdata"}, resp_rdata, exp_rd);
    chk({nm, " err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom); req_addr = $urandom; req_size = 3'($urandom);
      @(posedge clk); #1;
      chk({nm, " stall valid"}, 32'(resp_valid), 32'd1);
      chk({nm, " stall rdata"}, resp_rdata, exp_rd);
      chk({nm, " stall err"}, 32'(resp_err), 32'(exp_err));
      chk({nm, " stall req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({nm, " post valid"}, 32'(resp_valid), 32'd0);
    chk({nm, " post req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, " post busy"}, 32'(busy), 32'd0);
    chk({nm, " post rdata"}, resp_rdata, 32'h0);
  endtask

  task automatic txn_b(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = we; req_size_b = 3'b000; req_addr_b = addr; req_wdata_b = wd;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    lat = 0;
    while (!resp_valid_b && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(1 + WS_B));
    chk({nm, " rdata"}, resp_rdata_b, exp_rd);
    chk({nm, " err"}, 32'(resp_err_b), 32'd0);
    resp_ready_b = 1'b1;
    @(posedge clk); #1;
    resp_ready_b = 1'b0;
    chk({nm, " idle"}, 32'(req_ready_b), 32'd1);
  endtask

  initial begin
    logic [31:0] mrd;
    logic        mer;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] addr, wd;

    // Directed table; bytes are pre-initialised to addr+0x30 before it runs
    add(1, 3'd0, 8,  32'hDEADBEEF, 32'h0,        0, 0);
    add(0, 3'd0, 8,  32'h0,        32'hDEADBEEF, 0, 0);
    add(0, 3'd4, 8,  32'h0,        32'hFFFFFFEF, 0, 0);
    add(0, 3'd3, 8,  32'h0,        32'h000000EF, 0, 0);
    add(0, 3'd2, 10, 32'h0,        32'hFFFFDEAD, 0, 0);
    add(0, 3'd1, 10, 32'h0,        32'h0000DEAD, 0, 0);
    add(1, 3'd2, 12, 32'h12345678, 32'h0,        0, 0);
    add(0, 3'd0, 12, 32'h0,        32'h3F3E5678, 0, 0);
    add(1, 3'd4, 13, 32'hFFFFFFAA, 32'h0,        0, 0);
    add(0, 3'd1, 12, 32'h0,        32'h0000AA78, 0, 0);
    add(0, 3'd0, 6,  32'h0,        32'h0,        1, 0);
    add(0, 3'd2, 5,  32'h0,        32'h0,        1, 0);
    add(0, 3'd0, 78, 32'h0,        32'h0,        1, 0);
    add(0, 3'd7, 0,  32'h0,        32'h0,        1, 0);
    add(1, 3'd0, 6,  32'h12345678, 32'h0,        1, 0);
    add(0, 3'd0, 4,  32'h0,        32'h37363534, 0, 0);
    add(1, 3'd5, 0,  32'hCAFEBABE, 32'h0,        1, 0);
    add(0, 3'd0, 0,  32'h0,        32'h33323130, 0, 0);
    add(0, 3'd0, 76, 32'h0,        32'h7F7E7D7C, 0, 0);
    add(0, 3'd4, 79, 32'h0,        32'h0000007F, 0, 0);
    add(0, 3'd3, 80, 32'h0,        32'h0,        1, 0);
    add(0, 3'd2, 78, 32'h0,        32'h00007F7E, 0, 0);
    add(0, 3'd0, 8,  32'h0,        32'hDEADBEEF, 0, 5);
    add(0, 3'd4, 9,  32'h0,        32'hFFFFFFBE, 0, 2);
    add(0, 3'd0, 32'hFFFFFFFC, 32'h0, 32'h0,     1, 1);
    add(1, 3'd4, 79, 32'h00000080, 32'h0,        0, 0);
    add(0, 3'd4, 79, 32'h0,        32'hFFFFFF80, 0, 0);

    rst = 1'b1; rst_b = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_size_b = 3'd0; req_addr_b = 32'h0; req_wdata_b = 32'h0;
    resp_ready_b = 1'b0;
    #2;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata", resp_rdata, 32'h0);
    chk("reset err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("post-reset req_ready", 32'(req_ready), 32'd1);
    chk("post-reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < DEPTH / 4; i++) begin
      wd = {8'(4*i + 8'h33), 8'(4*i + 8'h32), 8'(4*i + 8'h31), 8'(4*i + 8'h30)};
      model(1'b1, 3'd0, 32'(4*i), wd, mrd, mer);
      run_txn($sformatf("init%0d", i), 1'b1, 3'd0, 32'(4*i), wd, 32'h0, 1'b0, 0);
    end

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, mrd, mer);
      run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd,
              tbl[i].rd, tbl[i].err, tbl[i].stall);
    end

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      sz = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) sz = 3'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0:       addr = $urandom | 32'hFFFFFF00;
        1:       addr = 32'($urandom_range(74, 90));
        default: addr = 32'($urandom_range(0, 79));
      endcase
      if ($urandom_range(0, 1) != 0) addr = addr & ~32'h3;
      wd = $urandom;
      model(we, sz, addr, wd, mrd, mer);
      run_txn($sformatf("rnd%0d", n), we, sz, addr, wd, mrd, mer, $urandom_range(0, 3));
    end

    // Asynchronous reset while a store waits: the store must not land
    txn_b("b_init", 1'b1, 32'd0, 32'hCAFEF00D, 32'h0);
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b1; req_size_b = 3'b000; req_addr_b = 32'd0;
    req_wdata_b = 32'h11111111;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    chk("b busy in wait", 32'(busy_b), 32'd1);
    @(posedge clk); #3;
    rst_b = 1'b1;
    #1;
    chk("b rst resp_valid", 32'(resp_valid_b), 32'd0);
    chk("b rst req_ready", 32'(req_ready_b), 32'd1);
    chk("b rst busy", 32'(busy_b), 32'd0);
    chk("b rst rdata", resp_rdata_b, 32'h0);
    chk("b rst err", 32'(resp_err_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b idle after reset", 32'(busy_b), 32'd0);
    txn_b("b_reload", 1'b0, 32'd0, 32'h0, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
